// File: rtl/program_loader_if.sv
// Byte-stream handshake between the host byte source (master) and the program loader (slave).
interface program_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/program_loader.sv
// Packs a big-endian byte stream into 32-bit words, writes them to instruction memory from address 0, then raises run.
// Optional: define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before run.
module program_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   prog_len,
  program_loader_if.slave       bs,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  run,
  output logic                  busy,
  output logic                  error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd5;
`endif

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_W   = 1;

  logic [2:0]          state;
  logic [ADDR_WIDTH:0] len;
  logic [ADDR_WIDTH:0] word_cnt;   // words written so far; doubles as the next write address
  logic [ADDR_WIDTH:0] word_cnt_nxt;
  logic [1:0]          byte_cnt;
  logic [31:0]         word;
  logic                accept;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]          csum;
`endif

  assign accept       = bs.byte_valid && bs.byte_ready;
  assign word_cnt_nxt = word_cnt + ONE_W;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      len        <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      word       <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else if (load_start) begin
      // Restart wins over anything else this cycle, including a byte being offered.
      len      <= prog_len;
      word_cnt <= '0;
      byte_cnt <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
      state    <= (prog_len == '0 || prog_len > MAX_LEN) ? S_ERR : S_RECV;
    end else begin
      case (state)
        S_RECV: if (accept) begin
          word     <= {word[23:0], bs.byte_data};
          byte_cnt <= byte_cnt + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum     <= csum ^ bs.byte_data;
`endif
          if (byte_cnt == 2'd3) begin
            // Capture the write port here so it holds its value after the write cycle.
            imem_addr  <= word_cnt[ADDR_WIDTH-1:0];
            imem_wdata <= {word[23:0], bs.byte_data};
            state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          word_cnt <= word_cnt_nxt;
          if (word_cnt_nxt == len) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state <= S_CHECK;
`else
            state <= S_RUN;
`endif
          end else begin
            state <= S_RECV;
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHECK: if (accept) begin
          state <= (bs.byte_data == csum) ? S_RUN : S_ERR;
        end
`endif
        default: ;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    bs.byte_ready = 1'b0;
    imem_we       = 1'b0;
    run           = 1'b0;
    busy          = 1'b0;
    error         = 1'b0;
    case (state)
      S_RECV: begin
        bs.byte_ready = 1'b1;
        busy          = 1'b1;
      end
      S_WRITE: begin
        imem_we = 1'b1;
        busy    = 1'b1;
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        bs.byte_ready = 1'b1;
        busy          = 1'b1;
      end
`endif
      S_RUN:   run   = 1'b1;
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the CPU's instruction-fetch interface: fills the instruction memory, then starts the core.
- Accepts a byte stream over a valid/ready handshake and packs it into 32-bit big-endian instruction words.
- Writes each word to consecutive word addresses from 0, then asserts Run to `single_cycle_cpu`.
- Sits between the host/bench byte source and the instruction memory write port plus the CPU Run input.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width; capacity 2^ADDR_WIDTH words.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Load_start  input  1  one-cycle pulse: latch Prog_len and (re)start loading.
- Prog_len  input  ADDR_WIDTH+1  number of words to load; sampled only on Load_start.
- Byte_valid  input  1  Byte_data is valid.
- Byte_data  input  8  stream byte, most-significant byte of each word first.
- Byte_ready  output  1  loader accepts a byte this cycle.
- Imem_we  output  1  instruction-memory write strobe, one cycle per word.
- Imem_addr  output  ADDR_WIDTH  word address of the write.
- Imem_wdata  output  32  instruction word.
- Run  output  1  CPU run enable.
- Busy  output  1  loading in progress.
- Error  output  1  load aborted; sticky until next Load_start.

Behaviour:
- Reset (async, Rst_n=0): all outputs 0; state IDLE; byte count, word count and address cleared. Reset mid-load discards any partial word. Run drops immediately.
- States: IDLE, RECV, WRITE, RUN, ERR.
- IDLE: Byte_ready=0, Busy=0, Run=0.
- Load_start has priority in every state. On the next cycle: Run=0, Error=0, address=0, byte count=0, length latched.
  - If Prog_len==0 or Prog_len>2^ADDR_WIDTH, go to ERR; otherwise go to RECV.
- RECV: Byte_ready=1, Busy=1.
  - A byte is accepted only when Byte_valid && Byte_ready. It shifts into the word register as {word[23:0], Byte_data}.
  - On the 4th accepted byte, go to WRITE.
- WRITE (exactly one cycle): Imem_we=1, Imem_addr=current address, Imem_wdata=assembled word, Byte_ready=0, Busy=1. Then:
  - address increments;
  - if words written == latched length, go to RUN; otherwise return to RECV.
- Latency: 4th byte of the last word accepted at cycle N; Imem_we=1 at N+1; Run=1 from N+2.
- RUN: Run=1, Busy=0, Byte_ready=0. Stays here until Load_start or reset. Bytes offered in this state are not accepted.
- ERR: Error=1, Run=0, Busy=0, Byte_ready=0, no memory writes.
- Address range: Imem_addr never exceeds latched length−1, so it never wraps. Prog_len==2^ADDR_WIDTH fills the whole memory, last write at address 2^ADDR_WIDTH−1.
- Load_start arriving in the same cycle as an accepted byte: the byte is dropped and the restart wins.
- Imem_addr and Imem_wdata hold their last values outside WRITE; they are meaningful only when Imem_we=1.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, a CHECK state (Byte_ready=1, Busy=1) accepts one extra byte.
  - The byte is compared with the XOR of all program bytes.
  - Match: go to RUN; Run=1 the cycle after the checksum byte is accepted.
  - Mismatch: go to ERR; Run stays 0 (memory contents remain written).
- Undefined: no CHECK state; behaviour exactly as above.

Test Plan:
- Reset then Load_start, Prog_len=2, bytes 20 08 00 05 20 09 00 07 with Byte_valid held high -> Imem_we pulses at addr 0 data 0x20080005 and at addr 1 data 0x20090007; Run=1 two cycles after the 8th byte; Busy=0.
- Same load with Byte_valid toggling every other cycle -> identical writes; no byte lost or duplicated; Byte_ready=0 during each WRITE cycle.
- Prog_len=0, and separately Prog_len=257 with ADDR_WIDTH=8 -> Error=1, no Imem_we, Run=0; a following valid Load_start clears Error.
- Rst_n pulled low after 6 of 8 bytes -> all outputs 0 at once. A reload with Prog_len=1 and bytes AA BB CC DD writes 0xAABBCCDD at addr 0; no stale bytes.
- Load_start while in RUN -> Run falls next cycle, Busy=1, reload starts at addr 0.
- With PROGRAM_LOADER_CHECKSUM_EN, Prog_len=1, bytes 01 02 04 08:
  - checksum byte 0F -> Run=1;
  - checksum byte 0E -> Error=1, Run=0.
